// File: rtl/code_sweep_pkg.sv
// Shared constants, state encoding and code helpers for the code sweep transmitter.
// The forbidden set is the one the companion detector rejects.
package code_sweep_pkg;

    localparam int VEC_W    = 5;
    localparam int FULL_CNT = 32;
    localparam int SKIP_CNT = 26;

    localparam logic [3:0] FORBID_A = 4'h0;
    localparam logic [3:0] FORBID_B = 4'h4;
    localparam logic [3:0] FORBID_C = 4'h8;

    localparam logic [VEC_W-1:0] LAST_IDX = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    function automatic logic is_forbidden(input logic [3:0] code);
        return (code == FORBID_A) || (code == FORBID_B) || (code == FORBID_C);
    endfunction

endpackage

// File: rtl/code_sweep_tx_tick_divider.sv
// Step-rate divider: emits a one-cycle tick after TICK_DIV uncleared cycles.
// Holding clr keeps the count at zero so every wait period starts fresh.
module tick_divider #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (cnt_reg == TERM) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/code_sweep_tx.sv
// Sweeps {en, code} vectors 0x00..0x1F at a divided rate over valid/ready,
// each paired with the result the code detector is expected to produce.
module code_sweep_tx
    import code_sweep_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_skip,
    input  logic              ready,
    output logic              valid,
    output logic [CODE_W-1:0] code_out,
    output logic              en_out,
    output logic              exp_hit,
    output logic              busy,
    output logic              done,
    output logic [5:0]        sent_cnt
);

    state_t             state_reg;
    logic [VEC_W-1:0]   idx_reg;
    logic               skip_reg;
    logic               valid_reg;
    logic [CODE_W-1:0]  code_reg;
    logic               en_reg;
    logic               hit_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [5:0]         sent_reg;

    logic [FULL_CNT-1:0] forbid_lut;
    logic [FULL_CNT-1:0] hit_lut;
    logic [VEC_W-1:0]    idx_inc;
    logic [VEC_W-1:0]    idx_next;
    logic [VEC_W-1:0]    first_idx;
    logic                tick;
    logic                div_clr;

    // Per-vector tables: forbidden flag and the detector's expected output.
    generate
        for (genvar gi = 0; gi < FULL_CNT; gi++) begin : g_lut
            assign forbid_lut[gi] = is_forbidden(4'(gi));
            assign hit_lut[gi]    = (gi >= 16) && !is_forbidden(4'(gi));
        end
    endgenerate

    // Forbidden codes are never adjacent, so at most one extra step is needed.
    always_comb begin
        idx_inc  = idx_reg + 5'd1;
        idx_next = (skip_reg && forbid_lut[idx_inc]) ? idx_reg + 5'd2 : idx_inc;
    end

    assign first_idx = (mode_skip && forbid_lut[0]) ? 5'd1 : 5'd0;

    // The divider only runs while waiting and restarts after every tick.
    assign div_clr = (state_reg != WAIT) || tick;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (div_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            skip_reg  <= 1'b0;
            valid_reg <= 1'b0;
            code_reg  <= '0;
            en_reg    <= 1'b0;
            hit_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sent_reg  <= '0;
        end else if (stop) begin
            // Abort keeps the last code and count visible for inspection.
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        skip_reg  <= mode_skip;
                        idx_reg   <= first_idx;
                        sent_reg  <= '0;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        code_reg  <= idx_reg[CODE_W-1:0];
                        en_reg    <= idx_reg[VEC_W-1];
                        hit_reg   <= hit_lut[idx_reg];
                        valid_reg <= 1'b1;
                        state_reg <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        valid_reg <= 1'b0;
                        if (sent_reg != 6'(FULL_CNT)) begin
                            sent_reg <= sent_reg + 6'd1;
                        end
                        if (idx_reg == LAST_IDX) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            state_reg <= WAIT;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign valid    = valid_reg;
    assign code_out = code_reg;
    assign en_out   = en_reg;
    assign exp_hit  = hit_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sent_cnt = sent_reg;

endmodule

// File: tb/tb_code_sweep_tx.sv
// Bench for code_sweep_tx: a fast (TICK_DIV=1) and a slow (TICK_DIV=3) instance,
// swept from a table of configurations against a list-based reference model.
module tb_code_sweep_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] stop_v = '0;
    logic [1:0] skip_v = '0;
    logic [1:0] ready_v = '0;
    logic [1:0] valid_v, en_v, hit_v, busy_v, done_v;
    logic [3:0] code_v [2];
    logic [5:0] sent_v [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_sweep_tx #(.TICK_DIV(1), .CODE_W(4)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
        .mode_skip(skip_v[0]), .ready(ready_v[0]), .valid(valid_v[0]),
        .code_out(code_v[0]), .en_out(en_v[0]), .exp_hit(hit_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sent_cnt(sent_v[0])
    );

    code_sweep_tx #(.TICK_DIV(3), .CODE_W(4)) dut_slow (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
        .mode_skip(skip_v[1]), .ready(ready_v[1]), .valid(valid_v[1]),
        .code_out(code_v[1]), .en_out(en_v[1]), .exp_hit(hit_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sent_cnt(sent_v[1])
    );

    typedef struct {
        int d;
        bit skip;
        int rdy_pct;
        bit noisy;
        int n_exp;
        int first_exp;
        int last_exp;
        int hits_exp;
    } sweep_vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int vec_of(input int d);
        return int'({en_v[d], code_v[d]});
    endfunction

    // Reference: a vector is forbidden when its low nibble is 0, 4 or 8.
    function automatic bit model_forbidden(input int v);
        int c;
        c = v % 16;
        return (c == 0) || (c == 4) || (c == 8);
    endfunction

    task automatic wait_valid(input int d, output int cyc);
        cyc = 0;
        while (!valid_v[d] && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic sweep(input sweep_vec_t t, output int n_got, output int first_v,
                         output int last_v, output int hits);
        int q[$];
        int tdiv;
        int waited;
        int stall;
        bit r;
        tdiv = (t.d == 0) ? 1 : 3;
        for (int v = 0; v < 32; v++) begin
            if (!(t.skip && model_forbidden(v))) q.push_back(v);
        end
        n_got = 0; first_v = -1; last_v = -1; hits = 0;
        skip_v[t.d] = t.skip;
        start_v[t.d] = 1'b1;
        step();
        start_v[t.d] = 1'b0;
        skip_v[t.d] = ~t.skip;
        check("start_busy", busy_v[t.d], 1);
        check("start_done", done_v[t.d], 0);
        check("start_cnt", sent_v[t.d], 0);
        foreach (q[i]) begin
            waited = 0;
            while (!valid_v[t.d] && waited < 20) begin
                ready_v[t.d] = 1'($urandom_range(0, 1));
                if (t.noisy) start_v[t.d] = ($urandom_range(0, 3) == 0);
                step();
                waited++;
            end
            start_v[t.d] = 1'b0;
            check("latency", waited, tdiv + 1);
            if (!valid_v[t.d]) return;
            check("vector", vec_of(t.d), q[i]);
            check("exp_hit", hit_v[t.d], ((q[i] >= 16) && !model_forbidden(q[i])) ? 1 : 0);
            if (first_v < 0) first_v = vec_of(t.d);
            last_v = vec_of(t.d);
            hits += hit_v[t.d];
            stall = 0;
            do begin
                r = ($urandom_range(1, 100) <= t.rdy_pct) || (stall >= 10);
                ready_v[t.d] = r;
                step();
                if (!r) begin
                    check("stall_vec", valid_v[t.d] ? vec_of(t.d) : -1, q[i]);
                    check("stall_cnt", sent_v[t.d], n_got);
                    stall++;
                end
            end while (!r);
            n_got++;
            check("hs_cnt", sent_v[t.d], n_got);
            check("hs_valid", valid_v[t.d], 0);
        end
        ready_v[t.d] = 1'b0;
        check("end_done", done_v[t.d], 1);
        check("end_busy", busy_v[t.d], 0);
        check("end_cnt", sent_v[t.d], q.size());
    endtask

    initial begin
        sweep_vec_t tbl[5];
        int n_got, first_v, last_v, hits, cyc;

        tbl[0] = '{d: 0, skip: 1'b0, rdy_pct: 100, noisy: 1'b0, n_exp: 32, first_exp: 8'h00, last_exp: 8'h1F, hits_exp: 13};
        tbl[1] = '{d: 0, skip: 1'b1, rdy_pct: 100, noisy: 1'b0, n_exp: 26, first_exp: 8'h01, last_exp: 8'h1F, hits_exp: 13};
        tbl[2] = '{d: 1, skip: 1'b1, rdy_pct: 60,  noisy: 1'b0, n_exp: 26, first_exp: 8'h01, last_exp: 8'h1F, hits_exp: 13};
        tbl[3] = '{d: 1, skip: 1'b0, rdy_pct: 50,  noisy: 1'b1, n_exp: 32, first_exp: 8'h00, last_exp: 8'h1F, hits_exp: 13};
        tbl[4] = '{d: 0, skip: 1'b0, rdy_pct: 70,  noisy: 1'b1, n_exp: 32, first_exp: 8'h00, last_exp: 8'h1F, hits_exp: 13};

        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", valid_v[d], 0);
            check("rst_busy", busy_v[d], 0);
            check("rst_done", done_v[d], 0);
            check("rst_cnt", sent_v[d], 0);
            check("rst_vec", vec_of(d), 0);
            check("rst_hit", hit_v[d], 0);
        end
        rst_n = 1'b1;
        step();

        // start and stop together from IDLE: stop wins.
        start_v[0] = 1'b1; stop_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        check("ss_busy", busy_v[0], 0);
        step(); step();
        check("ss_valid", valid_v[0], 0);
        check("ss_busy2", busy_v[0], 0);

        foreach (tbl[i]) begin
            sweep(tbl[i], n_got, first_v, last_v, hits);
            $display("sweep %0d: dut %0d skip %0d sent %0d first %02h last %02h hits %0d",
                     i, tbl[i].d, tbl[i].skip, n_got, first_v, last_v, hits);
            check("tbl_n", n_got, tbl[i].n_exp);
            check("tbl_first", first_v, tbl[i].first_exp);
            check("tbl_last", last_v, tbl[i].last_exp);
            check("tbl_hits", hits, tbl[i].hits_exp);
        end

        // Back-pressure at 0x07 on the slow instance, full mode.
        skip_v[1] = 1'b0; start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0; ready_v[1] = 1'b1;
        for (int v = 0; v < 7; v++) begin
            wait_valid(1, cyc);
            check("bp_vec", vec_of(1), v);
            step();
        end
        ready_v[1] = 1'b0;
        wait_valid(1, cyc);
        check("bp_vec7", vec_of(1), 7);
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp_hold_valid", valid_v[1], 1);
            check("bp_hold_vec", vec_of(1), 7);
            check("bp_hold_cnt", sent_v[1], 7);
        end
        ready_v[1] = 1'b1;
        step();
        check("bp_hs_valid", valid_v[1], 0);
        check("bp_hs_cnt", sent_v[1], 8);
        ready_v[1] = 1'b0;
        wait_valid(1, cyc);
        check("bp_gap", cyc, 4);
        check("bp_vec8", vec_of(1), 8);
        check("bp_hit8", hit_v[1], 0);
        stop_v[1] = 1'b1;
        step();
        stop_v[1] = 1'b0;
        check("pstop_valid", valid_v[1], 0);
        check("pstop_busy", busy_v[1], 0);
        check("pstop_cnt", sent_v[1], 8);
        check("pstop_vec", vec_of(1), 8);
        $display("backpressure: held 0x07 five cycles, next 0x%02h after %0d cycles", vec_of(1), cyc);

        // Stop in WAIT after ten vectors, then restart.
        skip_v[0] = 1'b0; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0; ready_v[0] = 1'b1;
        for (int v = 0; v < 10; v++) begin
            wait_valid(0, cyc);
            step();
        end
        ready_v[0] = 1'b0;
        stop_v[0] = 1'b1;
        step();
        stop_v[0] = 1'b0;
        check("wstop_valid", valid_v[0], 0);
        check("wstop_busy", busy_v[0], 0);
        check("wstop_done", done_v[0], 0);
        check("wstop_cnt", sent_v[0], 10);
        step(); step();
        check("wstop_idle", valid_v[0], 0);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        check("restart_cnt", sent_v[0], 0);
        check("restart_busy", busy_v[0], 1);
        wait_valid(0, cyc);
        check("restart_lat", cyc, 2);
        check("restart_vec", vec_of(0), 0);
        $display("stop in WAIT: restart vector 0x%02h after %0d cycles", vec_of(0), cyc);

        // Asynchronous reset while the slow instance presents a vector.
        skip_v[1] = 1'b0; start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        wait_valid(1, cyc);
        check("pre_rst_valid", valid_v[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", valid_v[1], 0);
        check("arst_busy", busy_v[1], 0);
        check("arst_done", done_v[1], 0);
        check("arst_cnt", sent_v[1], 0);
        check("arst_vec", vec_of(1), 0);
        check("arst_busy_fast", busy_v[0], 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) step();
        check("post_rst_valid", valid_v[1], 0);
        check("post_rst_busy", busy_v[1], 0);
        $display("async reset: valid %0d busy %0d after release", valid_v[1], busy_v[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
